cobra_hex_display: RTL

//  Downstream consumer of the CYBERcobra core's 32-bit out_o bus. Shows the value as 8 hex

---
 rtl/cobra_disp_pkg.sv | 36 +++
 rtl/hex_to_seg7.sv | 17 +
 rtl/cobra_hex_display.sv | 106 ++++++++++
 3 files changed

// File: rtl/cobra_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cobra_disp_pkg
// Brief   : Shared constants, types and helpers for the CYBERcobra hex display.
// Revision: 1.0 - initial release
// ============================================================================
package cobra_disp_pkg;

   localparam int DIGITS   = 8;
   localparam int NIBBLE_W = 4;

   typedef logic [6:0] seg_t;

   localparam seg_t         SEG_BLANK = 7'h7F;
   localparam logic [7:0]   AN_OFF    = 8'hFF;

   // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
   localparam seg_t HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Index of the most significant non-zero nibble; 0 when the value is zero
   function automatic logic [2:0] top_nibble(input logic [31:0] value);
      logic [2:0] msd;
      msd = 3'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (value[i*NIBBLE_W +: NIBBLE_W] != 4'h0) begin
            msd = 3'(i);
         end
      end
      return msd;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module  : hex_to_seg7
// Brief   : Combinational 4-bit nibble to active-low 7-segment pattern.
// Revision: 1.0 - initial release
// ============================================================================
module hex_to_seg7
   import cobra_disp_pkg::*;
(
   input  logic [3:0] nibble_i,
   output seg_t       seg_o
);

   assign seg_o = HEX_SEG[nibble_i];

endmodule
`default_nettype wire

// File: rtl/cobra_hex_display.sv
`default_nettype none
// ============================================================================
// Module  : cobra_hex_display
// Brief   : 8-digit multiplexed common-anode hex display driver for the
//           CYBERcobra out_o bus. Free-running scan, per-digit blank window,
//           value snapshotted once per frame so a frame never tears.
//           Optional build macro COBRA_HEX_LZB_EN enables leading-zero
//           blanking (digit 0 always shown).
// Revision: 1.0 - initial release
// ============================================================================
module cobra_hex_display
   import cobra_disp_pkg::*;
#(
   parameter int SCAN_DIV     = 100_000,
   parameter int BLANK_CYCLES = 1_000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] data_i,
   input  logic        hold_i,
   output logic [7:0]  an_o,
   output logic [6:0]  seg_o,
   output logic        dp_o
);

   localparam int                 c_DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
   localparam logic [c_DIV_W-1:0] c_BLANK    = c_DIV_W'(BLANK_CYCLES);

   logic [c_DIV_W-1:0] div_q;
   logic [2:0]         idx_q;
   logic [31:0]        snap_q;
   logic [7:0]         an_q,  an_d;
   seg_t               seg_q, seg_d;
   logic               dp_q,  dp_d;

   logic               w_div_wrap;
   logic               w_blank;
   logic               w_show;
   logic [3:0]         w_nibble;
   seg_t               w_seg;

   assign w_div_wrap = (div_q == c_DIV_LAST);
   assign w_blank    = (div_q < c_BLANK);
   assign w_nibble   = snap_q[{idx_q, 2'b00} +: NIBBLE_W];

`ifdef COBRA_HEX_LZB_EN
   // Digits above the most significant non-zero nibble stay dark
   assign w_show = (idx_q <= top_nibble(snap_q));
`else
   assign w_show = 1'b1;
`endif

   hex_to_seg7 u_hex_to_seg7 (
      .nibble_i (w_nibble),
      .seg_o    (w_seg)
   );

   // Scan divider, digit index and frame-boundary snapshot of the value
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         div_q  <= '0;
         idx_q  <= 3'd0;
         snap_q <= 32'h0;
      end else begin
         div_q <= w_div_wrap ? '0 : div_q + 1'b1;
         if (w_div_wrap) begin
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7 && !hold_i) begin
               snap_q <= data_i;
            end
         end
      end
   end

   // Next output values: dark during the blank window or a suppressed digit
   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (!w_blank && w_show) begin
         an_d  = ~(8'd1 << idx_q);
         seg_d = w_seg;
         dp_d  = ~((idx_q == 3'd0) && hold_i);
      end
   end

   // Registered pin drivers so the board never sees decode glitches
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         an_q  <= AN_OFF;
         seg_q <= SEG_BLANK;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign an_o  = an_q;
   assign seg_o = seg_q;
   assign dp_o  = dp_q;

endmodule
`default_nettype wire
